// File: rtl/decode_stage_pkg.sv
// Shared opcode/ALUop constants, decoded-field struct and output-register
// state type for the Kaiserlake decode stage.
package kl_decode_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // IR[12:11] value that selects the immediate form of MOV
    localparam logic [1:0] MOV_IMM = 2'b10;

    typedef struct packed {
        logic [2:0] opcode;
        logic       asel;
        logic       bsel;
        logic       loads;
        logic [1:0] alu_op;
        logic [1:0] shift;
        logic       write;
        logic [2:0] writenum;
        logic [2:0] num_rm;
        logic [2:0] num_rn;
        logic [2:0] num_rram;
        logic       use_rm;
        logic       use_rn;
        logic       use_rram;
        logic [7:0] imm;       // already sign-extended to 8 bits
        logic       illegal;
    } decoded_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and register-read-side signals of the decode stage, with
// master (environment) and slave (decode_stage) views.
interface decode_stage_if #(
    parameter int PC_W  = 8,
    parameter int IMM_W = 16,
    parameter int CNT_W = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       IR_in;
    logic [PC_W-1:0]   PC;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W+13:0]  control_out;
    logic [2:0]        num_Rm;
    logic [2:0]        num_Rn;
    logic [2:0]        num_Rram;
    logic [IMM_W-1:0]  sximm;
    logic              illegal;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, IR_in, PC, out_ready,
        input  in_ready, out_valid, control_out, num_Rm, num_Rn, num_Rram,
               sximm, illegal, stall_cnt
    );

    modport slave (
        input  flush, in_valid, IR_in, PC, out_ready,
        output in_ready, out_valid, control_out, num_Rm, num_Rn, num_Rram,
               sximm, illegal, stall_cnt
    );
endinterface

// File: rtl/decode_stage_logic.sv
// Purely combinational 16-bit instruction decoder: IR/PC to decoded_t plus
// the PC field of the control bundle (zero for NOP and illegal opcodes).
module kl_decode_logic
    import kl_decode_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [15:0]     ir,
    input  logic [PC_W-1:0] pc,
    output decoded_t        dec,
    output logic [PC_W-1:0] pc_field
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        dec      = '0;
        pc_field = '0;
        case (ir[15:13])
            OP_NOP: begin
            end
            OP_MOV: begin
                dec.opcode = OP_MOV;
                dec.write  = 1'b1;
                pc_field   = pc;
                if (ir[12:11] == MOV_IMM) begin
                    dec.asel     = 1'b1;
                    dec.bsel     = 1'b1;
                    dec.imm      = ir[7:0];
                    dec.writenum = ir[10:8];
                end else begin
                    dec.bsel     = 1'b1;
                    dec.writenum = ir[7:5];
                    dec.shift    = ir[4:3];
                    dec.num_rm   = ir[2:0];
                    dec.use_rm   = 1'b1;
                end
            end
            OP_ALU: begin
                dec.opcode = OP_ALU;
                pc_field   = pc;
                dec.alu_op = ir[12:11];
                dec.shift  = ir[4:3];
                dec.num_rm = ir[2:0];
                dec.use_rm = 1'b1;
                case (ir[12:11])
                    ALU_ADD, ALU_AND: begin
                        dec.num_rn   = ir[10:8];
                        dec.use_rn   = 1'b1;
                        dec.writenum = ir[7:5];
                        dec.write    = 1'b1;
                    end
                    ALU_CMP: begin
                        dec.num_rn = ir[10:8];
                        dec.use_rn = 1'b1;
                        dec.loads  = 1'b1;
                    end
                    ALU_MVN: begin
                        dec.writenum = ir[7:5];
                        dec.write    = 1'b1;
                    end
                endcase
            end
            OP_STR: begin
                dec.opcode   = OP_STR;
                pc_field     = pc;
                dec.bsel     = 1'b1;
                dec.num_rm   = ir[10:8];
                dec.use_rm   = 1'b1;
                dec.num_rram = ir[7:5];
                dec.use_rram = 1'b1;
                dec.imm      = {{3{ir[4]}}, ir[4:0]};
            end
            OP_LDR: begin
                dec.opcode   = OP_LDR;
                pc_field     = pc;
                dec.bsel     = 1'b1;
                dec.num_rm   = ir[10:8];
                dec.use_rm   = 1'b1;
                dec.writenum = ir[7:5];
                dec.write    = 1'b1;
                dec.imm      = {{3{ir[4]}}, ir[4:0]};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, flush and load-use
// interlock. Define KL_DECODE_HAZARD_EN to enable the interlock and stall_cnt.
module decode_stage
    import kl_decode_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);

`ifdef KL_DECODE_HAZARD_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    localparam int CTRL_W = PC_W + 14;

    decoded_t          dec;
    logic [PC_W-1:0]   pc_field;
    logic signed [7:0] imm_s;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [2:0]        rm_q, rn_q, rram_q;
    logic [IMM_W-1:0]  sximm_q;
    logic              illegal_q;
    ostate_t           state_q, state_d;
    logic              load;
    logic              in_ready;
    logic              src_match;
    logic              hazard;

    kl_decode_logic #(.PC_W(PC_W)) u_decode (
        .ir       (bus.IR_in),
        .pc       (bus.PC),
        .dec      (dec),
        .pc_field (pc_field)
    );

    assign imm_s  = dec.imm;
    assign ctrl_d = {dec.opcode, pc_field, dec.asel, dec.bsel, dec.loads,
                     dec.alu_op, dec.shift, dec.write, dec.writenum};

    // Use flags gate the compare: an unused source reads as register 0.
    assign src_match = (dec.use_rm   && dec.num_rm   == ctrl_q[2:0]) ||
                       (dec.use_rn   && dec.num_rn   == ctrl_q[2:0]) ||
                       (dec.use_rram && dec.num_rram == ctrl_q[2:0]);

    assign hazard = HAZARD_EN && (state_q == ST_FULL) &&
                    (ctrl_q[CTRL_W-1 -: 3] == OP_LDR) && bus.in_valid && src_match;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                in_ready = !bus.flush;
                if (bus.in_valid && in_ready) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                in_ready = !bus.flush && !hazard && bus.out_ready;
                if (bus.flush)
                    state_d = ST_EMPTY;
                else if (bus.in_valid && in_ready)
                    load = 1'b1;
                else if (bus.out_ready)
                    state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all registered state uses non-blocking assignment.
        // NOTE: datapath registers are reset as well, because every output must read 0 after reset.
        if (reset) begin
            state_q   <= ST_EMPTY;
            ctrl_q    <= '0;
            rm_q      <= '0;
            rn_q      <= '0;
            rram_q    <= '0;
            sximm_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ctrl_q    <= ctrl_d;
                rm_q      <= dec.num_rm;
                rn_q      <= dec.num_rn;
                rram_q    <= dec.num_rram;
                sximm_q   <= IMM_W'(imm_s);
                illegal_q <= dec.illegal;
            end
        end
    end

`ifdef KL_DECODE_HAZARD_EN
    logic [CNT_W-1:0] stall_q;

    // A bubble is counted only when the held LDR actually leaves.
    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (hazard && bus.out_ready && !bus.flush && stall_q != '1)
            stall_q <= stall_q + CNT_W'(1);
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.control_out = ctrl_q;
    assign bus.num_Rm      = rm_q;
    assign bus.num_Rn      = rn_q;
    assign bus.num_Rram    = rram_q;
    assign bus.sximm       = sximm_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, handshake corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_decode_stage;

    localparam int PC_W  = 8;
    localparam int IMM_W = 16;
    localparam int CNT_W = 3;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
`ifdef KL_DECODE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct {
        logic [21:0] ctrl;
        logic [2:0]  rm, rn, rram;
        logic [15:0] sx;
        logic        ill;
        logic [2:0]  op;
        logic [2:0]  wn;
        logic [7:0]  reads;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        int          pc;
        logic [21:0] ctrl;
        logic [2:0]  rm, rn, rram;
        logic [15:0] sx;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    decode_stage #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Control bundle: {opcode, PC, asel, bsel, loads, ALUop, shift, write, writenum}
    function automatic logic [21:0] mk(int op, int pc, int asel, int bsel, int loads,
                                       int aluop, int shift, int write, int wn);
        return {3'(op), 8'(pc), 1'(asel), 1'(bsel), 1'(loads), 2'(aluop),
                2'(shift), 1'(write), 3'(wn)};
    endfunction

    function automatic exp_t ref_decode(input logic [15:0] ir, input logic [7:0] pc);
        exp_t e;
        int op, sub, ra, rb, rc, sh, imm, loads, wr, wn;
        op  = int'(ir[15:13]);
        sub = int'(ir[12:11]);
        ra  = int'(ir[10:8]);
        rb  = int'(ir[7:5]);
        rc  = int'(ir[2:0]);
        sh  = int'(ir[4:3]);
        e.ctrl = '0; e.rm = '0; e.rn = '0; e.rram = '0; e.sx = '0;
        e.ill = 1'b0; e.op = '0; e.wn = '0; e.reads = '0;
        case (op)
            0: ;
            6: begin
                if (sub == 2) begin
                    imm = int'(ir[7:0]);
                    if (imm >= 128) imm -= 256;
                    e.sx = 16'(imm);
                    wn = ra;
                    e.ctrl = mk(6, pc, 1, 1, 0, 0, 0, 1, wn);
                end else begin
                    wn = rb;
                    e.rm = 3'(rc);
                    e.reads[rc] = 1'b1;
                    e.ctrl = mk(6, pc, 0, 1, 0, 0, sh, 1, wn);
                end
                e.op = 3'd6; e.wn = 3'(wn);
            end
            5: begin
                e.rm = 3'(rc);
                e.reads[rc] = 1'b1;
                loads = 0; wr = 1; wn = rb;
                if (sub != 3) begin
                    e.rn = 3'(ra);
                    e.reads[ra] = 1'b1;
                end
                if (sub == 1) begin
                    loads = 1; wr = 0; wn = 0;
                end
                e.ctrl = mk(5, pc, 0, 0, loads, sub, sh, wr, wn);
                e.op = 3'd5; e.wn = 3'(wn);
            end
            4, 3: begin
                imm = int'(ir[4:0]);
                if (imm >= 16) imm -= 32;
                e.sx = 16'(imm);
                e.rm = 3'(ra);
                e.reads[ra] = 1'b1;
                if (op == 4) begin
                    e.rram = 3'(rb);
                    e.reads[rb] = 1'b1;
                    e.ctrl = mk(4, pc, 0, 1, 0, 0, 0, 0, 0);
                end else begin
                    e.ctrl = mk(3, pc, 0, 1, 0, 0, 0, 1, rb);
                    e.wn = 3'(rb);
                end
                e.op = 3'(op);
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_control"},   bus.control_out, 0);
        check({tag, "_rm"},        bus.num_Rm, 0);
        check({tag, "_rn"},        bus.num_Rn, 0);
        check({tag, "_rram"},      bus.num_Rram, 0);
        check({tag, "_sximm"},     bus.sximm, 0);
        check({tag, "_illegal"},   bus.illegal, 0);
        check({tag, "_stall"},     bus.stall_cnt, 0);
    endtask

    task automatic check_held(input string tag, input exp_t e);
        check({tag, "_control"}, bus.control_out, e.ctrl);
        check({tag, "_rm"},      bus.num_Rm, e.rm);
        check({tag, "_rn"},      bus.num_Rn, e.rn);
        check({tag, "_rram"},    bus.num_Rram, e.rram);
        check({tag, "_sximm"},   bus.sximm, e.sx);
        check({tag, "_illegal"}, bus.illegal, e.ill);
    endtask

    // LDR R2,[R1,#4] followed by a second instruction offered the next cycle.
    task automatic ldr_then(input string tag, input logic [15:0] dep, input int lat_exp,
                            input logic rdy_exp, input int stall_exp);
        exp_t dep_e;
        int   lat;
        dep_e = ref_decode(dep, 8'h41);
        bus.in_valid = 1'b1; bus.IR_in = 16'h6144; bus.PC = 8'h40;
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.IR_in = dep; bus.PC = 8'h41;
        @(negedge clk);
        check({tag, "_ldr_out"}, bus.control_out, mk(3, 'h40, 0, 1, 0, 0, 0, 1, 2));
        check({tag, "_in_ready"}, bus.in_ready, rdy_exp);
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (bus.out_valid && bus.control_out == dep_e.ctrl) break;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_stall"}, bus.stall_cnt, stall_exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_ir();
        logic [2:0]  ops [8];
        logic [12:0] body;
        ops = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd7};
        body = 13'($urandom);
        // Narrow register fields to R0..R3 most of the time to provoke collisions.
        if ($urandom_range(3) != 0) body = body & ~13'h0484;
        return {ops[$urandom_range(7)], body};
    endfunction

    vec_t  vecs [13];
    exp_t  held [$];
    exp_t  e_in;
    int    m_stall;
    logic  hz, exp_rdy;

    initial begin
        vecs[0]  = '{16'hD3FE, 'h10, mk(6, 'h10, 1, 1, 0, 0, 0, 1, 3), 0, 0, 0, 16'hFFFE, 0};
        vecs[1]  = '{16'hD47F, 'h11, mk(6, 'h11, 1, 1, 0, 0, 0, 1, 4), 0, 0, 0, 16'h007F, 0};
        vecs[2]  = '{16'hC0BA, 'h12, mk(6, 'h12, 0, 1, 0, 0, 3, 1, 5), 2, 0, 0, 16'h0000, 0};
        vecs[3]  = '{16'hA285, 'h22, mk(5, 'h22, 0, 0, 0, 0, 0, 1, 4), 5, 2, 0, 16'h0000, 0};
        vecs[4]  = '{16'hAB1E, 'h23, mk(5, 'h23, 0, 0, 1, 1, 3, 0, 0), 6, 3, 0, 16'h0000, 0};
        vecs[5]  = '{16'hB7E9, 'h24, mk(5, 'h24, 0, 0, 0, 2, 1, 1, 7), 1, 7, 0, 16'h0000, 0};
        vecs[6]  = '{16'hBD47, 'h25, mk(5, 'h25, 0, 0, 0, 3, 0, 1, 2), 7, 0, 0, 16'h0000, 0};
        vecs[7]  = '{16'h867F, 'h30, mk(4, 'h30, 0, 1, 0, 0, 0, 0, 0), 6, 0, 3, 16'hFFFF, 0};
        vecs[8]  = '{16'h6144, 'h31, mk(3, 'h31, 0, 1, 0, 0, 0, 1, 2), 1, 0, 0, 16'h0004, 0};
        vecs[9]  = '{16'h2000, 'h32, 22'h0, 0, 0, 0, 16'h0000, 1};
        vecs[10] = '{16'h5FFF, 'h33, 22'h0, 0, 0, 0, 16'h0000, 1};
        vecs[11] = '{16'hFFFF, 'h34, 22'h0, 0, 0, 0, 16'h0000, 1};
        vecs[12] = '{16'h1FFF, 'h35, 22'h0, 0, 0, 0, 16'h0000, 0};

        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.IR_in = '0; bus.PC = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_zero("reset");
        check("reset_in_ready", bus.in_ready, 1);

        // Decode table: one instruction at a time, drained before the next.
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1; bus.IR_in = vecs[i].ir; bus.PC = 8'(vecs[i].pc);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_control", i), bus.control_out, vecs[i].ctrl);
            check($sformatf("vec%0d_rm", i), bus.num_Rm, vecs[i].rm);
            check($sformatf("vec%0d_rn", i), bus.num_Rn, vecs[i].rn);
            check($sformatf("vec%0d_rram", i), bus.num_Rram, vecs[i].rram);
            check($sformatf("vec%0d_sximm", i), bus.sximm, vecs[i].sx);
            check($sformatf("vec%0d_illegal", i), bus.illegal, vecs[i].ill);
            @(posedge clk); #1;
        end

        ldr_then("hazard", 16'hA285, HAZ ? 2 : 1, !HAZ, HAZ ? 1 : 0);
        ldr_then("nohazard", 16'hA185, 1, 1'b1, HAZ ? 1 : 0);

        // Back-pressure: a held bundle must not move while out_ready is low.
        bus.in_valid = 1'b1; bus.IR_in = 16'hD3FE; bus.PC = 8'h50; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.IR_in = 16'hC0BA; bus.PC = 8'h51;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_control", bus.control_out, mk(6, 'h50, 1, 1, 0, 0, 0, 1, 3));
            check("hold_sximm", bus.sximm, 16'hFFFE);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1 check("release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("release_control", bus.control_out, mk(6, 'h51, 0, 1, 0, 0, 3, 1, 5));
        check("release_out_valid", bus.out_valid, 1);

        // Flush while full with an instruction offered.
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.IR_in = 16'hD47F; bus.out_ready = 1'b0;
        #1 check("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        check("flush_not_accepted", bus.out_valid, 0);

        // Reset asserted in the cycle after the dependent instruction is offered.
        bus.in_valid = 1'b1; bus.IR_in = 16'h6144; bus.PC = 8'h60; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.IR_in = 16'hA285;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.in_valid = 1'b0;
        check_zero("mid_reset");

        // Randomized traffic against the reference model.
        held.delete();
        m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.IR_in     = rand_ir();
            bus.PC        = 8'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.flush     = ($urandom_range(15) == 0);
            @(negedge clk);
            e_in = ref_decode(bus.IR_in, bus.PC);
            hz = HAZ && held.size() != 0 && held[0].op == 3'd3 && bus.in_valid &&
                 e_in.reads[held[0].wn];
            exp_rdy = !bus.flush && !hz && (held.size() == 0 || bus.out_ready);
            check("rnd_in_ready", bus.in_ready, exp_rdy);
            check("rnd_out_valid", bus.out_valid, held.size() != 0);
            check("rnd_stall", bus.stall_cnt, m_stall);
            if (held.size() != 0) check_held("rnd", held[0]);
            @(posedge clk);
            if (hz && bus.out_ready && !bus.flush && m_stall < STALL_MAX) m_stall++;
            if (bus.flush)
                held.delete();
            else if (bus.in_valid && exp_rdy) begin
                held.delete();
                held.push_back(e_in);
            end else if (bus.out_ready)
                held.delete();
            #1;
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("final_stall", bus.stall_cnt, m_stall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised decode stage for the Kaiserlake pipeline. It accepts one 16-bit instruction plus its PC per valid/ready handshake and decodes it into the stage-0 control bundle, register numbers and sign-extended immediate. The result is held in an output register that supports back-pressure and flush. The block adds illegal-opcode flagging, a load-use interlock and a stall counter, and sits between instruction fetch and register read.

## Interface
- PC_W, 8: PC width; control bundle width is PC_W+14.
- IMM_W, 16: sximm width, ≥ 8.
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard output register and any accept this cycle.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- IR_in  in  16  instruction.
- PC  in  PC_W  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- control_out  out  PC_W+14  {opcode, PC, asel, bsel, loads, ALUop[1:0], shift[1:0], write, writenum[2:0]}.
- num_Rm, num_Rn, num_Rram  out  3 each  source register numbers; 0 when unused.
- sximm  out  IMM_W  sign-extended immediate.
- illegal  out  1  opcode 001, 010 or 111; the bundle is decoded as NOP.
- stall_cnt  out  CNT_W  saturating count of hazard-bubble cycles.

## Operation
- Decode per opcode:
  - 000 NOP: all fields 0.
  - 110 MOV: IR[12:11]=10 is the immediate form, with asel=bsel=1, sximm=sext(IR[7:0]) and writenum=IR[10:8]. Otherwise it is the register form, with bsel=1, writenum=IR[7:5], shift=IR[4:3] and Rm=IR[2:0]. write=1 for both forms.
  - 101 ALU: ALUop=IR[12:11].
    - ADD/AND (00/10): Rn=IR[10:8], Rd=IR[7:5], write=1.
    - CMP (01): Rn only, write=0, loads=1.
    - MVN (11): Rd, Rm, write=1.
    - All ALU ops take shift=IR[4:3] and Rm=IR[2:0].
  - 100 STR: bsel=1, Rm=IR[10:8], Rram=IR[7:5], sximm=sext(IR[4:0]).
  - 011 LDR: as STR, except write=1, writenum=IR[7:5] and no Rram.
- Each instruction also produces read-use flags (use_Rm, use_Rn, use_Rram). Hazard compares use them, never the zeroed number fields.
- hazard = out_valid && held opcode is LDR && an incoming used source register equals the held writenum.
- With no hazard and no flush, in_ready = !out_valid || out_ready.
- Output register states:
  - EMPTY to FULL on accept.
  - FULL stays FULL on simultaneous out-handshake and accept (new bundle loaded).
  - FULL to EMPTY on out-handshake with no accept.
- Hazard with out_ready=1: the LDR leaves, in_ready=0, and the register goes EMPTY (bubble). stall_cnt increments. The dependent instruction is accepted the next cycle.
- Hazard with out_ready=0: in_ready=0 and no count is taken.
- flush: out_valid goes to 0 next cycle, in_ready=0, and the accept is discarded. flush overrides hazard, and stall_cnt is not incremented.
- stall_cnt saturates at all-ones and clears only on reset.

## Timing
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle absent hazards.
- in_ready is combinational from out_valid, out_ready, flush, IR_in and the held state.
- While out_valid && !out_ready, all outputs are stable.
- Reset values: out_valid=0; control_out, num_*, sximm, illegal and stall_cnt all 0.
- Reset asserted mid-transfer wins over every other input.

## Configuration
- KL_DECODE_HAZARD_EN defined: load-use interlock and stall_cnt are active as described.
- KL_DECODE_HAZARD_EN undefined: hazard is tied to 0 and stall_cnt is tied to 0. Dependent instructions flow back-to-back and forwarding is the consumer's responsibility.

## Structure
- Package kl_decode_pkg holds:
  - opcode constants (OP_NOP, OP_MOV, OP_ALU, OP_STR, OP_LDR);
  - ALUop constants;
  - the decoded-fields struct, including the use flags and illegal.
- Sub-module kl_decode_logic: a purely combinational IR/PC-to-struct decoder. decode_stage wraps it with the output register, the handshake, the hazard logic and the counter.

## Test plan
- Reset, then IR 0xD3FE (MOV R3,#-2) → next cycle out_valid=1, writenum=3, write=1, asel=bsel=1, sximm=0xFFFE.
- IR 0x6144 (LDR R2,[R1,#4]) then 0xA285 (ADD R4,R2,R5), out_ready=1 → one bubble, in_ready=0 for 1 cycle, stall_cnt=1, ADD out 2 cycles after the LDR.
- LDR 0x6144 then 0xA185 (ADD R4,R1,R5) → no bubble, stall_cnt=0. Repeat the hazard case with the macro undefined → no bubble.
- IR 0x2000 → illegal=1, write=0, all fields 0.
- out_ready=0 for 5 cycles with a bundle held → outputs stable, in_ready=0. Raise out_ready → the next instruction loads the same cycle.
- flush while FULL and in_valid=1 → out_valid=0 next cycle, instruction not accepted. Reset during a hazard bubble → all outputs 0.
